rx_bert_seq: RTL and testbench

- Measurement sequencer that sits directly beside the Rx BERT and drives its PRBS/BER config inputs.
- Consumes the BERT's seed_good, shutoff and count outputs.
- Runs one measurement per i_start: clear, self-seed, lock check, timed count, drain, snapshot.
- Replaces manual scan-chain poking of seed/run/count enables during bring-up and automated sweeps.

---
 rtl/rx_bert_seq.sv | 99 +++++++++
 tb/tb_rx_bert_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_bert_seq.sv
// rx_bert_seq: runs one Rx BERT measurement per start pulse.
// Sequence: clear, self-seed, lock check, timed count, drain, snapshot.
module rx_bert_seq #(
   parameter int CountWidth  = 41,
   parameter int SeedCycles  = 64,
   parameter int LockCycles  = 8,
   parameter int LockTimeout = 1024,
   parameter int DwellWidth  = 32,
   parameter int DrainCycles = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [DwellWidth-1:0] i_cfg_dwell,
   input  logic                  i_prbs_seed_good,
   input  logic                  i_ber_shutoff,
   input  logic [CountWidth-1:0] i_ber_count,
   input  logic [CountWidth-1:0] i_bit_count,
   output logic                  o_bert_clr,
   output logic                  o_prbs_en,
   output logic                  o_prbs_seed_en,
   output logic                  o_prbs_run_en,
   output logic                  o_ber_count_en,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_lock_fail,
   output logic [CountWidth-1:0] o_err_snap,
   output logic [CountWidth-1:0] o_bit_snap,
   output logic [2:0]            o_state
);
   typedef enum logic [2:0] {IDLE, CLEAR, SEED, CHECK, COUNT, DRAIN, DONE, FAIL} state_t;
   localparam int LockW = $clog2(LockCycles + 1);
   state_t state_q, state_d;
   logic [DwellWidth-1:0] timer_q, timer_d, dwell_q, dwell_d;
   logic [LockW-1:0] lock_q, lock_d;
   logic capture;
   // timer_q counts cycles spent in the current state; CAPTURE is the final DRAIN cycle
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      lock_d = (state_q == CHECK && i_prbs_seed_good) ? lock_q + 1'b1 : '0;
      case (state_q)
         IDLE, DONE, FAIL: state_d = i_start ? CLEAR : state_q;
         CLEAR: state_d = SEED;
         SEED: state_d = (timer_q == DwellWidth'(SeedCycles - 1)) ? CHECK : SEED;
         CHECK: state_d = (lock_d == LockW'(LockCycles)) ? COUNT :
                          (timer_q == DwellWidth'(LockTimeout - 1)) ? FAIL : CHECK;
         COUNT: state_d = (i_ber_shutoff || (dwell_q != '0 && timer_q == dwell_q - 1'b1)) ? DRAIN : COUNT;
         default: begin
            capture = timer_q == DwellWidth'(DrainCycles);
            state_d = capture ? DONE : DRAIN;
         end
      endcase
      if (i_abort) begin
         state_d = IDLE;
         capture = 1'b0;
      end
      timer_d = (state_d != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + 1'b1;
      dwell_d = (state_q == CHECK && state_d == COUNT) ? i_cfg_dwell : dwell_q;
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         dwell_q <= '0;
         lock_q <= '0;
         o_bert_clr <= 1'b0;
         o_prbs_en <= 1'b0;
         o_prbs_seed_en <= 1'b0;
         o_prbs_run_en <= 1'b0;
         o_ber_count_en <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_lock_fail <= 1'b0;
         o_err_snap <= '0;
         o_bit_snap <= '0;
      end else if (i_en) begin
         state_q <= state_d;
         timer_q <= timer_d;
         dwell_q <= dwell_d;
         lock_q <= lock_d;
         o_bert_clr <= state_d == CLEAR;
         o_prbs_en <= state_d inside {SEED, CHECK, COUNT, DRAIN};
         o_prbs_seed_en <= state_d == SEED;
         o_prbs_run_en <= state_d inside {SEED, CHECK, COUNT, DRAIN};
         o_ber_count_en <= state_d == COUNT;
         o_busy <= state_d inside {CLEAR, SEED, CHECK, COUNT, DRAIN};
         o_done <= state_d == DONE;
         o_lock_fail <= state_d == FAIL;
         if (capture) begin
            o_err_snap <= i_ber_count;
            o_bit_snap <= i_bit_count;
         end
      end
   end
   assign o_state = state_q;
endmodule

// File: tb/tb_rx_bert_seq.sv
// tb_rx_bert_seq: directed bench with a BERT stub, a phase-level reference model
// checked every cycle, and hand-computed latency/snapshot expectations.
module tb_rx_bert_seq;
   localparam int CW = 41, DW = 32, SEEDC = 64, LOCKC = 8, TMO = 1024, DRAINC = 3;
   logic i_clk = 0, i_rst = 1, i_en = 1, i_start = 0, i_abort = 0;
   logic i_prbs_seed_good = 1, i_ber_shutoff = 0;
   logic [DW-1:0] i_cfg_dwell = 1000;
   logic [CW-1:0] i_ber_count = '0, i_bit_count = '0;
   logic o_bert_clr, o_prbs_en, o_prbs_seed_en, o_prbs_run_en, o_ber_count_en;
   logic o_busy, o_done, o_lock_fail;
   logic [CW-1:0] o_err_snap, o_bit_snap;
   logic [2:0] o_state;
   int n_chk = 0, n_fail = 0, good_mode = 0, tick = 0;
   logic inj = 0;
   int m_ph = 0, m_run = 0;
   longint m_age = 0;
   logic [DW-1:0] m_dw = '0;
   logic [CW-1:0] m_err = '0, m_bit = '0;
   always #5 i_clk = ~i_clk;
   rx_bert_seq dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start), .i_abort(i_abort),
      .i_cfg_dwell(i_cfg_dwell), .i_prbs_seed_good(i_prbs_seed_good), .i_ber_shutoff(i_ber_shutoff),
      .i_ber_count(i_ber_count), .i_bit_count(i_bit_count), .o_bert_clr(o_bert_clr),
      .o_prbs_en(o_prbs_en), .o_prbs_seed_en(o_prbs_seed_en), .o_prbs_run_en(o_prbs_run_en),
      .o_ber_count_en(o_ber_count_en), .o_busy(o_busy), .o_done(o_done), .o_lock_fail(o_lock_fail),
      .o_err_snap(o_err_snap), .o_bit_snap(o_bit_snap), .o_state(o_state)
   );
   // BERT stub: 8 bits per counted cycle, errors injected on demand
   always @(posedge i_clk) begin
      if (o_bert_clr) begin
         i_ber_count <= '0;
         i_bit_count <= '0;
      end else if (o_ber_count_en) begin
         i_bit_count <= i_bit_count + CW'(8);
         i_ber_count <= i_ber_count + CW'(inj);
      end
   end
   // mode 1 never offers more than 7 consecutive good cycles
   always @(negedge i_clk) begin
      tick++;
      i_prbs_seed_good = (good_mode == 0) ? 1'b1 : (tick % 8 != 7);
   end
   // phase model: phase number plus cycles already spent in it
   always @(posedge i_clk or posedge i_rst) begin
      int nxt;
      if (i_rst) begin
         m_ph = 0; m_age = 0; m_run = 0; m_dw = '0; m_err = '0; m_bit = '0;
      end else if (i_en) begin
         m_run = (m_ph == 3 && i_prbs_seed_good) ? m_run + 1 : 0;
         nxt = m_ph;
         if (i_abort) nxt = 0;
         else if (m_ph == 0 || m_ph >= 6) nxt = i_start ? 1 : m_ph;
         else if (m_ph == 1) nxt = 2;
         else if (m_ph == 2) nxt = (m_age + 1 == SEEDC) ? 3 : 2;
         else if (m_ph == 3) nxt = (m_run == LOCKC) ? 4 : (m_age + 1 == TMO) ? 7 : 3;
         else if (m_ph == 4) nxt = (i_ber_shutoff || (m_dw != 0 && m_age + 1 == longint'(m_dw))) ? 5 : 4;
         else if (m_age + 1 == DRAINC + 1) begin
            nxt = 6; m_err = i_ber_count; m_bit = i_bit_count;
         end
         if (m_ph == 3 && nxt == 4) m_dw = i_cfg_dwell;
         m_age = (nxt == m_ph) ? m_age + 1 : 0;
         m_ph = nxt;
      end
   end
   function automatic logic [10:0] exp_out(input int ph);
      logic act;
      act = ph >= 2 && ph <= 5;
      return {ph == 1, act, ph == 2, act, ph == 4, ph >= 1 && ph <= 5, ph == 6, ph == 7, 3'(ph)};
   endfunction
   wire [10:0] dut_vec = {o_bert_clr, o_prbs_en, o_prbs_seed_en, o_prbs_run_en, o_ber_count_en,
                          o_busy, o_done, o_lock_fail, o_state};
   always @(negedge i_clk) begin
      if (!i_rst) begin
         n_chk++;
         if (dut_vec !== exp_out(m_ph) || o_err_snap !== m_err || o_bit_snap !== m_bit) begin
            n_fail++;
            $display("FAIL model t=%0t outputs got %b err %0d bit %0d, want %b err %0d bit %0d",
                     $time, dut_vec, o_err_snap, o_bit_snap, exp_out(m_ph), m_err, m_bit);
         end
      end
   end
   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask
   task automatic pulse_start();
      i_start = 1;
      @(negedge i_clk);
      i_start = 0;
   endtask
   task automatic wait_for(input logic [2:0] s, input int lim, output int n);
      n = 0;
      while (o_state != s && n < lim) begin
         @(negedge i_clk);
         n++;
      end
      n_chk++;
      if (o_state != s) begin
         n_fail++;
         $display("FAIL wait_state%0d: got state %0d after %0d cycles", s, o_state, n);
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, n1, n2, seen;
      repeat (3) @(negedge i_clk);
      chk("rst_state", o_state, 0);
      chk("rst_busy", {o_busy, o_prbs_en, o_bert_clr, o_done, o_lock_fail}, 0);
      chk("rst_snap", o_bit_snap, 0);
      i_rst = 0;
      @(negedge i_clk);
      // clean run, dwell change during COUNT ignored
      pulse_start();
      chk("t1_clr", o_bert_clr, 1);
      wait_for(3'd4, 200, n1);
      chk("t1_to_count", n1, 73);
      i_cfg_dwell = 5;
      wait_for(3'd6, 2000, n2);
      chk("t1_latency", n1 + n2, 1077);
      chk("t1_done", o_done, 1);
      chk("t1_err", o_err_snap, 0);
      chk("t1_bits", o_bit_snap, 8000);
      // 5 injected errors, stray start in COUNT ignored
      i_cfg_dwell = 1000;
      pulse_start();
      wait_for(3'd4, 200, n);
      repeat (100) @(negedge i_clk);
      inj = 1;
      i_start = 1;
      repeat (5) @(negedge i_clk);
      inj = 0;
      i_start = 0;
      wait_for(3'd6, 2000, n);
      chk("t2_err", o_err_snap, 5);
      chk("t2_bits", o_bit_snap, 8000);
      repeat (20) @(negedge i_clk);
      chk("t2_err_hold", o_err_snap, 5);
      chk("t2_done_hold", o_done, 1);
      // lock never reached
      good_mode = 1;
      pulse_start();
      wait_for(3'd7, 3000, n);
      chk("t3_fail_latency", n, 1089);
      chk("t3_lock_fail", o_lock_fail, 1);
      chk("t3_enables", {o_prbs_en, o_prbs_run_en, o_prbs_seed_en, o_ber_count_en, o_busy}, 0);
      chk("t3_err", o_err_snap, 5);
      chk("t3_bits", o_bit_snap, 8000);
      good_mode = 0;
      // dwell 0, shutoff in COUNT cycle 200
      i_cfg_dwell = 0;
      pulse_start();
      chk("t4_clear_fail", o_lock_fail, 0);
      wait_for(3'd4, 200, n);
      repeat (199) @(negedge i_clk);
      i_ber_shutoff = 1;
      @(negedge i_clk);
      i_ber_shutoff = 0;
      chk("t4_drain", o_state, 5);
      chk("t4_cnt_en", o_ber_count_en, 0);
      wait_for(3'd6, 50, n);
      chk("t4_drain_len", n, DRAINC + 1);
      chk("t4_bits", o_bit_snap, 1600);
      chk("t4_err", o_err_snap, 0);
      // abort in COUNT, then a full rerun
      i_cfg_dwell = 1000;
      pulse_start();
      wait_for(3'd4, 200, n);
      repeat (50) @(negedge i_clk);
      i_abort = 1;
      i_start = 1;
      @(negedge i_clk);
      chk("t5_idle", o_state, 0);
      chk("t5_cnt_en", o_ber_count_en, 0);
      chk("t5_busy", o_busy, 0);
      chk("t5_done", o_done, 0);
      chk("t5_snap", o_bit_snap, 1600);
      i_abort = 0;
      i_start = 0;
      @(negedge i_clk);
      chk("t5_still_idle", o_state, 0);
      pulse_start();
      wait_for(3'd6, 2000, n);
      chk("t5_rerun", n, 1077);
      chk("t5_bits", o_bit_snap, 8000);
      // enable dropped for 10 cycles in SEED, async reset in CHECK
      pulse_start();
      wait_for(3'd2, 10, n);
      seen = 1;
      for (int k = 0; k < 200 && o_state == 3'd2; k++) begin
         if (seen == 10) i_en = 0;
         if (seen == 20) i_en = 1;
         @(negedge i_clk);
         if (o_state == 3'd2) seen++;
      end
      i_en = 1;
      chk("t6_seed_wall", seen, 74);
      wait_for(3'd3, 5, n);
      repeat (3) @(negedge i_clk);
      #2 i_rst = 1;
      #1;
      chk("t6_rst_state", o_state, 0);
      chk("t6_rst_outs", {o_prbs_en, o_prbs_run_en, o_busy, o_done, o_bert_clr}, 0);
      chk("t6_rst_snap", o_bit_snap, 0);
      @(negedge i_clk);
      i_rst = 0;
      repeat (3) @(negedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
